nios_nios2_qsys_0_div_cell: RTL and testbench
=============================================

Name: nios_nios2_qsys_0_div_cell

Overview:
- Iterative 32-bit integer divider for the Nios II M-stage. It is the inverse counterpart of the multiply cell.
- Computes quotient or remainder, signed or unsigned, radix-2 restoring, one quotient bit per clock.
- Issued by the CPU stall logic with a start pulse. Completion is signalled by a one-cycle done pulse, and the result is held until the next start.

Parameters:
- DATA_WIDTH, 32: operand and result width. Counter width is ceil(log2(DATA_WIDTH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- M_div_start  in  1  start request; sampled only when M_div_busy=0.
- M_div_signed  in  1  1 = two's-complement operands; 0 = unsigned. Captured at start.
- M_div_want_rem  in  1  1 = return remainder; 0 = return quotient. Captured at start.
- M_div_src1  in  DATA_WIDTH  dividend, captured at start.
- M_div_src2  in  DATA_WIDTH  divisor, captured at start.
- M_div_cell_result  out  DATA_WIDTH  quotient or remainder; registered.
- M_div_busy  out  1  high from the cycle after start is accepted until done.
- M_div_done  out  1  one-cycle pulse; M_div_cell_result is valid from this cycle.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, M_div_cell_result=0, M_div_busy=0, M_div_done=0, counter=0, internal registers=0. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with M_div_start=1, at the clock edge:
  - latch operands, signed and want_rem flags;
  - take absolute values when signed (abs(0x80000000) = 0x80000000 as an unsigned magnitude);
  - record neg_q = sign1 XOR sign2 and neg_r = sign1;
  - record dz = (src2==0);
  - remainder accumulator R=0, Q=|src1|, counter=DATA_WIDTH-1;
  - go to CALC, busy=1.
- CALC, once per cycle:
  - {R,Q} shifted left by 1; trial = R_shifted - |src2|;
  - if trial >= 0: R=trial and Q LSB=1; else Q LSB=0;
  - when counter==0 go to FIX, else decrement counter;
  - exactly DATA_WIDTH CALC cycles.
- FIX, one cycle:
  - apply signs: quotient = neg_q ? -Q : Q; remainder = neg_r ? -R : R.
  - Divide by zero overrides: quotient = all ones, remainder = src1 unmodified, for both signed and unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural wrap, no trap).
  - Load M_div_cell_result with the selected value and go to DONE.
- DONE, one cycle: M_div_done=1, M_div_busy=0.
  - Next state is IDLE, or CALC if M_div_start=1 (back-to-back issue allowed).
- Latency: start accepted at edge E0; M_div_done is high in the cycle after edge E0+DATA_WIDTH+1, i.e. 34 cycles for 32-bit. Fixed latency, data independent, including divide by zero.
- M_div_start while busy=1 is ignored, and operands are not re-sampled.
- M_div_cell_result changes only on the FIX to DONE transition and otherwise holds its value through IDLE.
- Remainder sign follows the dividend. Quotient truncates toward zero, per Nios II div/divu semantics.

Test Plan:
- Unsigned 100 / 7, want_rem=0 then 1: done exactly 34 cycles after start, results 14 and then 2; busy high for 33 cycles.
- Signed 0xFFFFFFF9 (-7) / 2: quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7 / -2: quotient 0xFFFFFFFD, remainder 1.
- 0x80000000 / 0xFFFFFFFF: signed gives quotient 0x80000000, remainder 0; unsigned gives quotient 0, remainder 0x80000000.
- Divide by zero, src1=0x12345678, src2=0, both signed modes: quotient 0xFFFFFFFF, remainder 0x12345678, done still at cycle 34.
- Start pulses during busy with different operands: ignored, and the first result is returned. Start asserted in the DONE cycle: a second operation begins immediately and its done comes 34 cycles later.
- Reset asserted asynchronously mid-CALC (counter=15): all outputs 0 immediately, no done pulse. A new start after reset release completes normally.

Source files
------------

// File: rtl/nios_nios2_qsys_0_div_cell_if.sv
// Issue/result bundle between the M-stage stall logic and the divide cell.
interface nios_nios2_qsys_0_div_cell_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  M_div_start;
   logic                  M_div_signed;
   logic                  M_div_want_rem;
   logic [DATA_WIDTH-1:0] M_div_src1;
   logic [DATA_WIDTH-1:0] M_div_src2;
   logic [DATA_WIDTH-1:0] M_div_cell_result;
   logic                  M_div_busy;
   logic                  M_div_done;

   modport master (
      output M_div_start, M_div_signed, M_div_want_rem, M_div_src1, M_div_src2,
      input  M_div_cell_result, M_div_busy, M_div_done
   );

   modport slave (
      input  M_div_start, M_div_signed, M_div_want_rem, M_div_src1, M_div_src2,
      output M_div_cell_result, M_div_busy, M_div_done
   );
endinterface

// File: rtl/nios_nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider: quotient or remainder, signed or unsigned,
// one quotient bit per clock, fixed latency.
module nios_nios2_qsys_0_div_cell #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   nios_nios2_qsys_0_div_cell_if.slave   div
);
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam int unsigned W     = DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          state, state_nxt;
   logic            busy_q, done_q, busy_nxt, done_nxt;
   logic [W-1:0]    r_q, q_q, d_q, src1_q, result_q;
   logic [CNT_W-1:0] cnt_q;
   logic            neg_q_q, neg_r_q, dz_q, want_rem_q;

   logic            accept_c;
   logic            sign1_c, sign2_c;
   logic [W-1:0]    abs1_c, abs2_c;
   logic [W:0]      r_sh_c;
   logic            ge_c;
   logic [W-1:0]    r_sub_c, q_fix_c, r_fix_c;

   assign accept_c = ((state == S_IDLE) || (state == S_DONE)) && div.M_div_start;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (accept_c) state_nxt = S_CALC;
         S_CALC: if (cnt_q == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = accept_c ? S_CALC : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode, registered below so busy/done come straight from flops
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      unique case (state_nxt)
         S_CALC, S_FIX: busy_nxt = 1'b1;
         S_DONE:        done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   // Operand magnitudes; abs of the most negative value wraps to itself, which is
   // the correct unsigned magnitude.
   always_comb begin
      sign1_c = div.M_div_signed & div.M_div_src1[W-1];
      sign2_c = div.M_div_signed & div.M_div_src2[W-1];
      abs1_c  = sign1_c ? W'(-div.M_div_src1) : div.M_div_src1;
      abs2_c  = sign2_c ? W'(-div.M_div_src2) : div.M_div_src2;
   end

   // One restoring step; R stays below the divisor so only the shifted value needs W+1 bits
   always_comb begin
      r_sh_c  = {r_q, q_q[W-1]};
      ge_c    = (r_sh_c >= {1'b0, d_q});
      r_sub_c = W'(r_sh_c - {1'b0, d_q});
   end

   always_comb begin
      q_fix_c = neg_q_q ? W'(-q_q) : q_q;
      r_fix_c = neg_r_q ? W'(-r_q) : r_q;
      if (dz_q) begin
         q_fix_c = '1;
         r_fix_c = src1_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         src1_q     <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         dz_q       <= 1'b0;
         want_rem_q <= 1'b0;
      end else if (accept_c) begin
         r_q        <= '0;
         q_q        <= abs1_c;
         d_q        <= abs2_c;
         src1_q     <= div.M_div_src1;
         cnt_q      <= CNT_W'(DATA_WIDTH - 1);
         neg_q_q    <= sign1_c ^ sign2_c;
         neg_r_q    <= sign1_c;
         dz_q       <= (div.M_div_src2 == '0);
         want_rem_q <= div.M_div_want_rem;
      end else if (state == S_CALC) begin
         r_q   <= ge_c ? r_sub_c : r_sh_c[W-1:0];
         q_q   <= {q_q[W-2:0], ge_c};
         if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      end else if (state == S_FIX) begin
         result_q <= want_rem_q ? r_fix_c : q_fix_c;
      end
   end

   assign div.M_div_cell_result = result_q;
   assign div.M_div_busy        = busy_q;
   assign div.M_div_done        = done_q;
endmodule

// File: tb/tb_nios_nios2_qsys_0_div_cell.sv
// Directed bench for the divide cell: results, latency, busy window, ignored
// restarts, back-to-back issue and asynchronous reset abort.
module tb_nios_nios2_qsys_0_div_cell;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   nios_nios2_qsys_0_div_cell_if #(.DATA_WIDTH(32)) div_if ();

   nios_nios2_qsys_0_div_cell #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .div   (div_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drives a start pulse at the current negedge; returns one negedge later.
   task automatic issue(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b);
      div_if.M_div_signed   = s;
      div_if.M_div_want_rem = r;
      div_if.M_div_src1     = a;
      div_if.M_div_src2     = b;
      div_if.M_div_start    = 1'b1;
      @(negedge clk);
      div_if.M_div_start    = 1'b0;
   endtask

   // Runs one operation; lat counts clock edges from start acceptance, inclusive.
   task automatic op(input string tag, input bit s, input bit r,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit inject);
      int lat;
      int busy_cnt;
      issue(s, r, a, b);
      lat      = 1;
      busy_cnt = 0;
      while (!div_if.M_div_done && lat < 100) begin
         if (div_if.M_div_busy) busy_cnt++;
         if (inject && lat == 5) begin
            div_if.M_div_signed   = ~s;
            div_if.M_div_want_rem = ~r;
            div_if.M_div_src1     = 32'h0000_DEAD;
            div_if.M_div_src2     = 32'h0000_0003;
            div_if.M_div_start    = 1'b1;
         end
         if (inject && lat == 6) div_if.M_div_start = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({tag, "_done"}, 32'(div_if.M_div_done), 32'd1);
      check({tag, "_lat"}, 32'(lat), 32'd34);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
      check({tag, "_busy_in_done"}, 32'(div_if.M_div_busy), 32'd0);
      check({tag, "_result"}, div_if.M_div_cell_result, exp);
   endtask

   initial begin
      int done_seen;
      reset                 = 1'b1;
      div_if.M_div_start    = 1'b0;
      div_if.M_div_signed   = 1'b0;
      div_if.M_div_want_rem = 1'b0;
      div_if.M_div_src1     = '0;
      div_if.M_div_src2     = '0;
      repeat (2) @(negedge clk);
      check("rst_result", div_if.M_div_cell_result, 32'h0);
      check("rst_busy", 32'(div_if.M_div_busy), 32'd0);
      check("rst_done", 32'(div_if.M_div_done), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      op("u100d7_q", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
      op("u100d7_r", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0);

      // Result must hold and done must drop after the pulse
      repeat (3) @(negedge clk);
      check("hold_result", div_if.M_div_cell_result, 32'd2);
      check("hold_done", 32'(div_if.M_div_done), 32'd0);

      op("sm7d2_q", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      op("sm7d2_r", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      op("s7dm2_q", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
      op("s7dm2_r", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);

      op("smin_q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      op("smin_r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
      op("umin_q", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
      op("umin_r", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

      op("dz_u_q", 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0);
      op("dz_u_r", 1'b0, 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0);
      op("dz_s_q", 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0);
      op("dz_s_r", 1'b1, 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0);

      // Start pulse while busy is ignored; then a restart in the DONE cycle
      op("ignore", 1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 1'b1);
      op("b2b", 1'b0, 1'b1, 32'd1000, 32'd7, 32'd6, 1'b0);

      // Abort mid-CALC with counter at 15
      @(negedge clk);
      issue(1'b0, 1'b0, 32'd100, 32'd7);
      repeat (16) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_result", div_if.M_div_cell_result, 32'h0);
      check("arst_busy", 32'(div_if.M_div_busy), 32'd0);
      check("arst_done", 32'(div_if.M_div_done), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_if.M_div_done || div_if.M_div_busy) done_seen++;
      end
      check("arst_no_done", 32'(done_seen), 32'd0);
      op("post_rst", 1'b0, 1'b0, 32'd255, 32'd16, 32'd15, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
